dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, DRAM byte-address width.
REQ-002 Parameter DATA_W, default 8, DRAM data width.
REQ-003 Parameter MEM_DEPTH, default 307200, number of valid DRAM addresses, 0 to MEM_DEPTH-1.
REQ-004 Parameter RD_LAT, default 1, cycles from DRAM ren strobe to valid DRAM rdata.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 pN_req  in  1  request from port N (N=0,1), held until granted.
REQ-009 pN_we  in  1  1 = write, 0 = read; valid while pN_req is high.
REQ-010 pN_addr  in  ADDR_W  access address.
REQ-011 pN_wdata  in  DATA_W  write data.
REQ-012 pN_gnt  out  1  request accepted this cycle.
REQ-013 pN_err  out  1  one-cycle pulse: granted request was out of range and discarded.
REQ-014 pN_rvalid  out  1  one-cycle pulse: pN_rdata holds read data.
REQ-015 pN_rdata  out  DATA_W  read return data.
REQ-016 flush_req  in  1  level request to dump DRAM contents to file.
REQ-017 flush_done  out  1  one-cycle pulse: flush completed.
REQ-018 ren, wen  out  1 each  DRAM read and write strobes.
REQ-019 raddr, waddr  out  ADDR_W each  DRAM read and write addresses.
REQ-020 wdata  out  DATA_W  DRAM write data.
REQ-021 writefile  out  1  DRAM file-dump strobe.
REQ-022 rdata  in  DATA_W  DRAM read data.

Function
REQ-023 FSM states: ARB, DRAIN, FLUSH, DONE.
- ARB: grants allowed.
- DRAIN: no grants; waits until no read is in flight.
- FLUSH: writefile=1 for exactly one cycle.
- DONE: flush_done=1 for one cycle; next state ARB.
REQ-024 In ARB, flush_req=1 SHALL move the FSM to DRAIN with no grant in that cycle; flush has priority over pending requests.
REQ-025 DRAIN SHALL go to FLUSH in the first cycle with zero reads in flight (immediately if none are in flight).
REQ-026 In ARB, at most one pN_gnt SHALL be high per cycle; grants are combinational from req in the same cycle.
REQ-027 Arbitration SHALL be two-way round robin. With both requests high, the port not granted last wins. Reset priority is port 0.
REQ-028 A granted in-range request SHALL drive exactly one registered DRAM strobe (ren or wen) on the next cycle, with matching address and data. All other DRAM strobes are 0.
REQ-029 pN_rvalid SHALL pulse RD_LAT+1 cycles after pN_gnt for a read, with pN_rdata = DRAM rdata. Reads return in grant order.
REQ-030 The read-in-flight tracker SHALL be a RD_LAT+1 deep shift register of {valid, port} tags. Back-to-back reads every cycle are supported.
REQ-031 An address >= MEM_DEPTH SHALL still be granted. pN_err pulses the following cycle. No DRAM strobe is issued and no rvalid is produced.
REQ-032 A write SHALL produce no rvalid. A read and a write to the same address in consecutive grants SHALL be ordered as granted.
REQ-033 A request deasserted before its grant SHALL be dropped silently.

Reset
REQ-034 While rst_n=0, the following SHALL be 0: all outputs (gnt, err, rvalid, rdata, ren, wen, raddr, waddr, wdata, writefile, flush_done), the FSM (ARB), the round-robin pointer (port 0) and all in-flight tags.
REQ-035 Reset asserted mid-operation SHALL discard in-flight reads: no rvalid after reset release.

Structure
REQ-036 Shared package dram_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH, RD_LAT defaults and the FSM state enum.
REQ-037 Two-way round-robin logic SHALL be sub-module rr_arb2 (inputs req[1:0], update; output gnt[1:0]).

Verification
REQ-038 p1 read at 0x00000 granted in cycle t -> ren=1, raddr=0 in cycle t+1; p1_rvalid in t+2 with DRAM data.
REQ-039 p0 and p1 both hold read requests for 6 cycles -> grants p0,p1,p0,p1,p0,p1; six rvalids, each to its own port.
REQ-040 p0 write 0xA5 to 0x4AFFF, then p1 read 0x4AFFF -> p1_rdata=0xA5.
REQ-041 p0 read at 0x4B000 -> p0_gnt=1, p0_err pulse next cycle, ren=wen=0, no p0_rvalid.
REQ-042 flush_req raised the cycle after a read grant -> no grants until done; rvalid first; writefile one cycle later; flush_done the cycle after that.
REQ-043 rst_n pulled low one cycle after a read grant -> all outputs 0; no rvalid after release; next grant goes to p0 on a tie.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared defaults and types for the two-port DRAM arbiter.
package dram_pkg;

    localparam int DRAM_ADDR_W    = 19;
    localparam int DRAM_DATA_W    = 8;
    localparam int DRAM_MEM_DEPTH = 307200;
    localparam int DRAM_RD_LAT    = 1;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // One entry of the read-return pipeline: which port gets the data.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Client ports, flush handshake and DRAM-side strobes of the arbiter, bundled.
interface dram_arbiter_if #(
    parameter int ADDR_W = dram_pkg::DRAM_ADDR_W,
    parameter int DATA_W = dram_pkg::DRAM_DATA_W
);

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_err;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_err;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              flush_req;
    logic              flush_done;

    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              writefile;
    logic [DATA_W-1:0] rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  flush_req, rdata,
        output p0_gnt, p0_err, p0_rvalid, p0_rdata,
        output p1_gnt, p1_err, p1_rvalid, p1_rdata,
        output flush_done, ren, wen, raddr, waddr, wdata, writefile
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output flush_req, rdata,
        input  p0_gnt, p0_err, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_err, p1_rvalid, p1_rdata,
        input  flush_done, ren, wen, raddr, waddr, wdata, writefile
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the port that lost the last granted tie-break
// (or was idle) wins the next tie. Reset favours port 0.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // prio_q = 1 means port 1 wins a tie.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt    = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
        if (update && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port DRAM arbiter with read-return tagging and a drain-then-dump flush.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_ARB   | grants allowed; flush_req moves to ST_DRAIN
// ST_DRAIN | no grants; wait until every in-flight read returns
// ST_FLUSH | writefile strobe for one cycle
// ST_DONE  | flush_done pulse for one cycle, back to ST_ARB
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int ADDR_W    = DRAM_ADDR_W,
    parameter int DATA_W    = DRAM_DATA_W,
    parameter int MEM_DEPTH = DRAM_MEM_DEPTH,
    parameter int RD_LAT    = DRAM_RD_LAT
) (
    input  logic           clk,
    input  logic           rst_n,
    dram_arbiter_if.slave  bus
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic              grant_en;
    logic [1:0]        arb_req;
    logic [1:0]        gnt;

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    logic              ren_q,   ren_d;
    logic              wen_q,   wen_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        err_q,   err_d;

    // Stage 0 aligns with the ren strobe; stage RD_LAT aligns with rdata.
    rd_tag_t [RD_LAT:0] tag_q;
    rd_tag_t [RD_LAT:0] tag_d;
    rd_tag_t            ret_tag;
    logic               rd_pending;

    logic              p0_rvalid;
    logic              p1_rvalid;

    assign grant_en = rst_n && (state_q == ST_ARB) && !bus.flush_req;
    assign arb_req  = grant_en ? {bus.p1_req, bus.p0_req} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (arb_req),
        .update (|gnt),
        .gnt    (gnt)
    );

    always_comb begin
        sel       = gnt[1];
        sel_we    = sel ? bus.p1_we    : bus.p0_we;
        sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
        // Extra MSB so a depth equal to 2**ADDR_W still compares correctly.
        in_range  = {1'b0, sel_addr} < (ADDR_W + 1)'(MEM_DEPTH);
    end

    always_comb begin
        ren_d   = (|gnt) && in_range && !sel_we;
        wen_d   = (|gnt) && in_range && sel_we;
        raddr_d = ren_d ? sel_addr  : '0;
        waddr_d = wen_d ? sel_addr  : '0;
        wdata_d = wen_d ? sel_wdata : '0;
        err_d   = in_range ? 2'b00 : gnt;
    end

    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = ren_d;
        tag_d[0].port  = sel;
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Only tags that will still be outstanding after this edge count; the
    // final stage is returning its data in the current cycle.
    always_comb begin
        rd_pending = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            rd_pending = rd_pending | tag_q[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARB:   if (bus.flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (!rd_pending)   state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 2'b00;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
        end
    end

    assign ret_tag   = tag_q[RD_LAT];
    assign p0_rvalid = ret_tag.valid && !ret_tag.port;
    assign p1_rvalid = ret_tag.valid &&  ret_tag.port;

    assign bus.p0_gnt     = gnt[0];
    assign bus.p1_gnt     = gnt[1];
    assign bus.p0_err     = err_q[0];
    assign bus.p1_err     = err_q[1];
    assign bus.p0_rvalid  = p0_rvalid;
    assign bus.p1_rvalid  = p1_rvalid;
    assign bus.p0_rdata   = p0_rvalid ? bus.rdata : '0;
    assign bus.p1_rdata   = p1_rvalid ? bus.rdata : '0;
    assign bus.ren        = ren_q;
    assign bus.wen        = wen_q;
    assign bus.raddr      = raddr_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.writefile  = (state_q == ST_FLUSH);
    assign bus.flush_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed, table-driven bench for dram_arbiter with a small behavioural DRAM.
module tb_dram_arbiter;

    logic clk;
    logic rst_n;

    dram_arbiter_if bus ();

    dram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0;
        logic        w0;
        logic [18:0] a0;
        logic [7:0]  d0;
        logic        r1;
        logic        w1;
        logic [18:0] a1;
        logic [7:0]  d1;
        logic        fl;
    } stim_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  err;
        logic [1:0]  rv;
        logic        ren;
        logic        wen;
        logic        wf;
        logic        fd;
        logic [18:0] raddr;
        logic [18:0] waddr;
        logic [7:0]  wdata;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // DRAM model: unwritten locations read back as addr[7:0] + 0x11.
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] dflt(input logic [18:0] a);
        return a[7:0] + 8'h11;
    endfunction

    always @(posedge clk) begin
        if (bus.wen) mem[int'(bus.waddr)] = bus.wdata;
        if (bus.ren) bus.rdata <= mem.exists(int'(bus.raddr)) ? mem[int'(bus.raddr)] : dflt(bus.raddr);
    end

    task automatic drive(input stim_t s);
        bus.p0_req    = s.r0;
        bus.p0_we     = s.w0;
        bus.p0_addr   = s.a0;
        bus.p0_wdata  = s.d0;
        bus.p1_req    = s.r1;
        bus.p1_we     = s.w1;
        bus.p1_addr   = s.a1;
        bus.p1_wdata  = s.d1;
        bus.flush_req = s.fl;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.gnt   = {bus.p1_gnt, bus.p0_gnt};
        o.err   = {bus.p1_err, bus.p0_err};
        o.rv    = {bus.p1_rvalid, bus.p0_rvalid};
        o.ren   = bus.ren;
        o.wen   = bus.wen;
        o.wf    = bus.writefile;
        o.fd    = bus.flush_done;
        o.raddr = bus.raddr;
        o.waddr = bus.waddr;
        o.wdata = bus.wdata;
        o.rd0   = bus.p0_rdata;
        o.rd1   = bus.p1_rdata;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got gnt=%b err=%b rv=%b ren=%b wen=%b wf=%b fd=%b raddr=%h waddr=%h wdata=%h rd0=%h rd1=%h, expected gnt=%b err=%b rv=%b ren=%b wen=%b wf=%b fd=%b raddr=%h waddr=%h wdata=%h rd0=%h rd1=%h",
                     name, act.gnt, act.err, act.rv, act.ren, act.wen, act.wf, act.fd, act.raddr, act.waddr, act.wdata, act.rd0, act.rd1,
                     exp.gnt, exp.err, exp.rv, exp.ren, exp.wen, exp.wf, exp.fd, exp.raddr, exp.waddr, exp.wdata, exp.rd0, exp.rd1);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vq[$];
        vec_t  v;
        stim_t s;
        obs_t  e;

        // k0-k3: single p1 read at address 0
        v = '{default: '0}; v.s.r1 = 1; v.s.a1 = 19'h0; v.e.gnt = 2'b10; vq.push_back(v);
        v = '{default: '0}; v.e.ren = 1; v.e.raddr = 19'h0; vq.push_back(v);
        v = '{default: '0}; v.e.rv = 2'b10; v.e.rd1 = 8'h11; vq.push_back(v);
        v = '{default: '0}; vq.push_back(v);
        // k4-k12: both ports hold reads, alternating grants and returns
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h010; v.s.r1 = 1; v.s.a1 = 19'h021; v.e.gnt = 2'b01; vq.push_back(v);
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h012; v.s.r1 = 1; v.s.a1 = 19'h021; v.e.gnt = 2'b10; v.e.ren = 1; v.e.raddr = 19'h010; vq.push_back(v);
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h012; v.s.r1 = 1; v.s.a1 = 19'h023; v.e.gnt = 2'b01; v.e.ren = 1; v.e.raddr = 19'h021; v.e.rv = 2'b01; v.e.rd0 = 8'h21; vq.push_back(v);
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h014; v.s.r1 = 1; v.s.a1 = 19'h023; v.e.gnt = 2'b10; v.e.ren = 1; v.e.raddr = 19'h012; v.e.rv = 2'b10; v.e.rd1 = 8'h32; vq.push_back(v);
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h014; v.s.r1 = 1; v.s.a1 = 19'h025; v.e.gnt = 2'b01; v.e.ren = 1; v.e.raddr = 19'h023; v.e.rv = 2'b01; v.e.rd0 = 8'h23; vq.push_back(v);
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h016; v.s.r1 = 1; v.s.a1 = 19'h025; v.e.gnt = 2'b10; v.e.ren = 1; v.e.raddr = 19'h014; v.e.rv = 2'b10; v.e.rd1 = 8'h34; vq.push_back(v);
        v = '{default: '0}; v.e.ren = 1; v.e.raddr = 19'h025; v.e.rv = 2'b01; v.e.rd0 = 8'h25; vq.push_back(v);
        v = '{default: '0}; v.e.rv = 2'b10; v.e.rd1 = 8'h36; vq.push_back(v);
        v = '{default: '0}; vq.push_back(v);
        // k13-k16: write then read the last valid address
        v = '{default: '0}; v.s.r0 = 1; v.s.w0 = 1; v.s.a0 = 19'h4AFFF; v.s.d0 = 8'hA5; v.e.gnt = 2'b01; vq.push_back(v);
        v = '{default: '0}; v.s.r1 = 1; v.s.a1 = 19'h4AFFF; v.e.gnt = 2'b10; v.e.wen = 1; v.e.waddr = 19'h4AFFF; v.e.wdata = 8'hA5; vq.push_back(v);
        v = '{default: '0}; v.e.ren = 1; v.e.raddr = 19'h4AFFF; vq.push_back(v);
        v = '{default: '0}; v.e.rv = 2'b10; v.e.rd1 = 8'hA5; vq.push_back(v);
        // k17-k21: first out-of-range address (read) and far out-of-range write
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h4B000; v.e.gnt = 2'b01; vq.push_back(v);
        v = '{default: '0}; v.e.err = 2'b01; vq.push_back(v);
        v = '{default: '0}; vq.push_back(v);
        v = '{default: '0}; v.s.r1 = 1; v.s.w1 = 1; v.s.a1 = 19'h7FFFF; v.s.d1 = 8'h77; v.e.gnt = 2'b10; vq.push_back(v);
        v = '{default: '0}; v.e.err = 2'b10; vq.push_back(v);
        // k22-k29: flush right after a read grant, with p1 waiting
        v = '{default: '0}; v.s.r0 = 1; v.s.a0 = 19'h033; v.e.gnt = 2'b01; vq.push_back(v);
        v = '{default: '0}; v.s.fl = 1; v.s.r1 = 1; v.s.a1 = 19'h044; v.e.ren = 1; v.e.raddr = 19'h033; vq.push_back(v);
        v = '{default: '0}; v.s.fl = 1; v.s.r1 = 1; v.s.a1 = 19'h044; v.e.rv = 2'b01; v.e.rd0 = 8'h44; vq.push_back(v);
        v = '{default: '0}; v.s.fl = 1; v.s.r1 = 1; v.s.a1 = 19'h044; v.e.wf = 1; vq.push_back(v);
        v = '{default: '0}; v.s.r1 = 1; v.s.a1 = 19'h044; v.e.fd = 1; vq.push_back(v);
        v = '{default: '0}; v.s.r1 = 1; v.s.a1 = 19'h044; v.e.gnt = 2'b10; vq.push_back(v);
        v = '{default: '0}; v.e.ren = 1; v.e.raddr = 19'h044; vq.push_back(v);
        v = '{default: '0}; v.e.rv = 2'b10; v.e.rd1 = 8'h55; vq.push_back(v);
        // k30-k34: flush with nothing in flight
        v = '{default: '0}; v.s.fl = 1; vq.push_back(v);
        v = '{default: '0}; v.s.fl = 1; vq.push_back(v);
        v = '{default: '0}; v.e.wf = 1; vq.push_back(v);
        v = '{default: '0}; v.e.fd = 1; vq.push_back(v);
        v = '{default: '0}; vq.push_back(v);

        rst_n = 1'b0;
        drive('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_idle", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].s);
            @(negedge clk);
            check($sformatf("vec%0d", i), vq[i].e);
            next_cycle();
        end

        // Reset while a read is in flight and port 1 is requesting.
        s = '0; s.r0 = 1; s.a0 = 19'h055;
        drive(s);
        @(negedge clk);
        e = '0; e.gnt = 2'b01;
        check("rst_pre_grant", e);
        next_cycle();
        s = '0; s.r1 = 1; s.a1 = 19'h066;
        drive(s);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_asserted", '0);
        next_cycle();
        @(negedge clk);
        check("rst_held", '0);
        next_cycle();
        rst_n = 1'b1;
        drive('0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_after%0d", i), '0);
            next_cycle();
        end

        s = '0; s.r0 = 1; s.a0 = 19'h077; s.r1 = 1; s.a1 = 19'h088;
        drive(s);
        @(negedge clk);
        e = '0; e.gnt = 2'b01;
        check("rst_tie_p0", e);
        next_cycle();
        drive('0);
        @(negedge clk);
        e = '0; e.ren = 1; e.raddr = 19'h077;
        check("rst_tie_ren", e);
        next_cycle();
        @(negedge clk);
        e = '0; e.rv = 2'b01; e.rd0 = 8'h88;
        check("rst_tie_rvalid", e);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
